// File: rtl/timebase_pkg.sv
// Shared types and default constants for the timebase controller.
package timebase_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam int DIV_DEFAULT        = 50_000_000;
    localparam int DEB_CYCLES_DEFAULT = 500_000;
    localparam int REP_DELAY_DEFAULT  = 25_000_000;
    localparam int REP_PERIOD_DEFAULT = 5_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/timebase_debounce.sv
// Button conditioning: 2-flop synchroniser, stability-count debouncer and
// a one-cycle pulse on each accepted rising level.
module debounce
    import timebase_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES);

    logic sync1;
    logic sync2;
    logic level_d;
    logic [CNT_W-1:0] stable_cnt;

    // A sample equal to the accepted level restarts the count, so any bounce
    // back during the window discards the candidate level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/timebase_ctrl.sv
// Run/stop timebase: CEN every DIV cycles while running, INC pulses while stopped.
// Define TIMEBASE_AUTO_REPEAT_EN to compile in hold-to-repeat for the INC button.
module timebase_ctrl
    import timebase_pkg::*;
#(
    parameter int DIV        = DIV_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int REP_DELAY  = REP_DELAY_DEFAULT,
    parameter int REP_PERIOD = REP_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_inc,
    output logic CEN,
    output logic INC,
    output logic run
);

    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    if (DIV < 2 || DEB_CYCLES < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_check
        $error("timebase_ctrl: DIV must be >= 2 and all other counts >= 1");
    end

    logic run_level;
    logic run_press;
    logic inc_level;
    logic inc_press;
    logic inc_q;
    logic [PRE_W-1:0] pre_cnt;

    debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_run),
        .level (run_level),
        .press (run_press)
    );

    debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
        .level (inc_level),
        .press (inc_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
        end else if (run_press && run_level) begin
            run <= ~run;
        end
    end

    // Held at zero while stopped so the first CEN lands a full period after start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (!run || pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign CEN = run && (pre_cnt == PRE_LAST);

`ifdef TIMEBASE_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(max_int(REP_DELAY, REP_PERIOD) + 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);

    rep_state_t rep_state;
    logic [REP_W-1:0] rep_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_state <= IDLE;
            rep_cnt   <= '0;
            inc_q     <= 1'b0;
        end else begin
            inc_q <= 1'b0;
            case (rep_state)
                IDLE: begin
                    rep_cnt <= '0;
                    if (inc_press && !run) begin
                        rep_state <= DELAY;
                        inc_q     <= 1'b1;
                    end
                end
                DELAY: begin
                    if (!inc_level || run) begin
                        rep_state <= IDLE;
                        rep_cnt   <= '0;
                    end else if (rep_cnt == DELAY_LAST) begin
                        rep_state <= REPEAT;
                        rep_cnt   <= '0;
                        inc_q     <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end
                REPEAT: begin
                    if (!inc_level || run) begin
                        rep_state <= IDLE;
                        rep_cnt   <= '0;
                    end else if (rep_cnt == PERIOD_LAST) begin
                        rep_cnt <= '0;
                        inc_q   <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end
                default: begin
                    rep_state <= IDLE;
                    rep_cnt   <= '0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_q <= 1'b0;
        end else begin
            inc_q <= inc_press && inc_level && !run;
        end
    end
`endif

    // Gating on the live run state keeps INC and CEN mutually exclusive.
    assign INC = inc_q && !run;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Self-checking bench for timebase_ctrl; honours TIMEBASE_AUTO_REPEAT_EN.
module tb_timebase_ctrl;

    localparam int DIV  = 10;
    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int HLEN = DEB + 3;

`ifdef TIMEBASE_AUTO_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic btn_run;
    logic btn_inc;
    logic CEN;
    logic INC;
    logic run;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int inc_seen = 0;

    // Reference model: raw sample history per button, accepted levels, run state.
    logic run_hist [HLEN];
    logic inc_hist [HLEN];
    logic m_deb_run, m_deb_inc, m_rose_run, m_rose_inc;
    logic m_run, m_cen, m_inc;
    int   run_start;
    int   rep_origin;
    bit   rep_active;

    timebase_ctrl #(
        .DIV        (DIV),
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_run (btn_run),
        .btn_inc (btn_inc),
        .CEN     (CEN),
        .INC     (INC),
        .run     (run)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        for (int i = 0; i < HLEN; i++) begin
            run_hist[i] = 1'b0;
            inc_hist[i] = 1'b0;
        end
        m_deb_run  = 1'b0;
        m_deb_inc  = 1'b0;
        m_rose_run = 1'b0;
        m_rose_inc = 1'b0;
        m_run      = 1'b0;
        m_cen      = 1'b0;
        m_inc      = 1'b0;
        run_start  = 0;
        rep_origin = 0;
        rep_active = 1'b0;
    endtask

    // A level is accepted once the raw input has shown it on DEB+1 consecutive
    // edges, ending two edges back (synchroniser delay).
    task automatic modelStep(input logic r_run, input logic r_inc, input logic r_rst);
        logic prev_run, prev_deb_inc, prev_rose_run, prev_rose_inc, pulse;
        logic all_run, all_inc;
        if (r_rst) begin
            modelReset();
            return;
        end
        prev_run      = m_run;
        prev_deb_inc  = m_deb_inc;
        prev_rose_run = m_rose_run;
        prev_rose_inc = m_rose_inc;
        for (int i = HLEN - 1; i > 0; i--) begin
            run_hist[i] = run_hist[i-1];
            inc_hist[i] = inc_hist[i-1];
        end
        run_hist[0] = r_run;
        inc_hist[0] = r_inc;
        all_run = 1'b1;
        all_inc = 1'b1;
        for (int i = 2; i < HLEN; i++) begin
            if (run_hist[i] == m_deb_run) all_run = 1'b0;
            if (inc_hist[i] == m_deb_inc) all_inc = 1'b0;
        end
        m_rose_run = all_run && !m_deb_run;
        m_rose_inc = all_inc && !m_deb_inc;
        if (all_run) m_deb_run = ~m_deb_run;
        if (all_inc) m_deb_inc = ~m_deb_inc;

        m_run = prev_run ^ prev_rose_run;
        if (m_run && !prev_run) run_start = cyc;
        m_cen = m_run && (((cyc - run_start) % DIV) == DIV - 1);

        pulse = 1'b0;
        if (rep_active) begin
            if (!prev_deb_inc || prev_run)
                rep_active = 1'b0;
            else if ((cyc - rep_origin) >= RD && ((cyc - rep_origin - RD) % RP) == 0)
                pulse = 1'b1;
        end
        if (prev_rose_inc && !prev_run) begin
            pulse = 1'b1;
            if (REPEAT_EN) begin
                rep_active = 1'b1;
                rep_origin = cyc;
            end
        end
        m_inc = pulse && !m_run;
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkBit("cen", CEN, m_cen);
        checkBit("inc", INC, m_inc);
        checkBit("run", run, m_run);
        checkBit("cen_inc_exclusive", CEN & INC, 1'b0);
        if (INC === 1'b1) inc_seen++;
    endtask

    task automatic applyStimulus(input logic r, input logic i);
        btn_run = r;
        btn_inc = i;
    endtask

    task automatic tick(input int n);
        logic r_run, r_inc, r_rst;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            r_run = btn_run;
            r_inc = btn_inc;
            r_rst = rst;
            cyc++;
            #1;
            modelStep(r_run, r_inc, r_rst);
            checkOutput();
        end
    endtask

    task automatic asyncReset();
        rst = 1'b1;
        #1;
        checkBit("async_rst_cen", CEN, 1'b0);
        checkBit("async_rst_inc", INC, 1'b0);
        checkBit("async_rst_run", run, 1'b0);
        tick(3);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        modelReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        tick(3);
        rst = 1'b0;
        tick(3);

        // Clean run press: run rises, CEN cadence, no INC.
        base = inc_seen;
        applyStimulus(1'b1, 1'b0);
        tick(10);
        applyStimulus(1'b0, 1'b0);
        tick(35);
        checkBit("run_started", run, 1'b1);
        checkCount("no_inc_while_running", inc_seen - base, 0);

        // INC press while running is discarded.
        applyStimulus(1'b0, 1'b1);
        tick(12);
        applyStimulus(1'b0, 1'b0);
        tick(30);
        checkCount("inc_discarded_running", inc_seen - base, 0);

        // Stop.
        applyStimulus(1'b1, 1'b0);
        tick(10);
        applyStimulus(1'b0, 1'b0);
        tick(15);
        checkBit("run_stopped", run, 1'b0);

        // Bounce 1-0-1 then hold: one INC.
        base = inc_seen;
        applyStimulus(1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1);
        tick(15);
        applyStimulus(1'b0, 1'b0);
        tick(15);
        checkCount("bounce_single_inc", inc_seen - base, 1);

        // Long hold of 60 cycles.
        base = inc_seen;
        applyStimulus(1'b0, 1'b1);
        tick(60);
        applyStimulus(1'b0, 1'b0);
        tick(25);
        checkCount("hold60_inc_count", inc_seen - base, REPEAT_EN ? 9 : 1);

        // Reset while counting.
        applyStimulus(1'b1, 1'b0);
        tick(10);
        applyStimulus(1'b0, 1'b0);
        tick(14);
        asyncReset();
        tick(30);
        checkBit("run_after_reset", run, 1'b0);

        // Reset during a long INC hold, button kept high across release.
        applyStimulus(1'b0, 1'b1);
        tick(40);
        asyncReset();
        tick(30);
        applyStimulus(1'b0, 1'b0);
        tick(15);

        // Randomised button activity.
        for (int s = 0; s < 60; s++) begin
            applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            tick($urandom_range(1, 30));
        end
        applyStimulus(1'b0, 1'b0);
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
